// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and default line settings.
// Used by the transmitter today and the receiver later.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_state_t;

    // Clocks per bit for a given system clock and line rate.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Request/response bundle between the upload controller (master) and the
// UART transmitter (slave). The serial pin itself is not part of the bundle.
interface uart_tx_if;
    import uart_pkg::*;

    logic                   tx_en;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_stop;
    logic                   busy;

    modport master (
        output tx_en,
        output tx_data,
        input  tx_stop,
        input  busy
    );

    modport slave (
        input  tx_en,
        input  tx_data,
        output tx_stop,
        output busy
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..DIV-1 and flags the terminal count with a
// one-cycle tick. A synchronous clear holds the count at zero so the owner
// can align the first bit period to a frame start.
module baud_tick_gen #(
    parameter int DIV = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] TERMINAL = 16'(DIV - 1);

    logic [15:0] count;

    assign tick = !clear && (count == TERMINAL);

    // Free-running bit counter that wraps on every tick and parks at zero while cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes a level-held byte request and sends it LSB-first as
// an 8N1 frame on txd, then pulses tx_stop for one cycle so the controller can
// drop its request. Defining UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD,
    parameter int DIV      = calc_div(CLK_FREQ, BAUD)
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      txd
);

    uart_state_t            state;
    logic [UART_DATA_W-1:0] shift_reg;
    logic [2:0]             bit_idx;
    logic                   baud_clear;
    logic                   baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    // The bit timer only runs while a frame is on the line, so every frame's
    // start bit begins with a fresh count.
    assign baud_clear = (state == IDLE) || (state == DONE);

    baud_tick_gen #(
        .DIV   (DIV)
    ) u_baud_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte captured at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_bit <= 1'b0;
        end else if (state == IDLE && bus.tx_en) begin
            parity_bit <= ^bus.tx_data;
        end
    end
`endif

    // Frame sequencer; txd, busy and tx_stop are registered here so the pin never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_idx     <= '0;
            txd         <= 1'b1;
            bus.tx_stop <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.tx_stop <= 1'b0;
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    bus.busy <= 1'b0;
                    if (bus.tx_en) begin
                        shift_reg <= bus.tx_data;
                        bit_idx   <= '0;
                        txd       <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        txd     <= shift_reg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= parity_bit;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            txd       <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        txd         <= 1'b1;
                        bus.tx_stop <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    txd      <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    txd      <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with DIV=4. Expected bytes are queued when a
// request is driven; a line monitor decodes each frame on txd and compares it
// against the queue, including tx_stop/busy framing and start-to-stop latency.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int STOP_LATENCY = FRAME_BITS * DIV + 1;
    localparam int FRAME_PERIOD = FRAME_BITS * DIV + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd;

    uart_tx_if bus();

    uart_tx #(
        .DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .txd (txd)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int stop_count  = 0;
    int abort_count = 0;
    logic [7:0] sb[$];
    int fall_q[$];

    // Cycle stamp used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Count every tx_stop pulse seen on the bus.
    always @(negedge clk) if (bus.tx_stop === 1'b1) stop_count <= stop_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Expected line levels in time order: start, data LSB first, [parity], stop.
    function automatic logic [31:0] frameBits(input logic [7:0] d);
        logic [31:0] v;
        v = '0;
        v[8:1] = d;
`ifdef UART_TX_PARITY_EN
        v[9]  = ^d;
        v[10] = 1'b1;
`else
        v[9]  = 1'b1;
`endif
        return v;
    endfunction

    task automatic monitorFrame();
        logic [31:0] expv;
        logic [31:0] rxv;
        logic [7:0]  d;
        int          glitches;
        bit          aborted;
        rxv      = '0;
        glitches = 0;
        aborted  = 1'b0;
        fall_q.push_back(cyc);
        checkOutput("frame_expected", 32'(sb.size() > 0), 1);
        d    = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        expv = frameBits(d);
        for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
            for (int s = 0; s < DIV && !aborted; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (rst !== 1'b1) begin
                    aborted = 1'b1;
                end else begin
                    if (s == DIV / 2) rxv[b] = txd;
                    if (txd !== expv[b]) glitches++;
                    if (bus.tx_stop !== 1'b0) glitches++;
                    if (bus.busy !== 1'b1) glitches++;
                end
            end
        end
        if (aborted) begin
            abort_count++;
            return;
        end
        checkOutput("frame_bits", rxv, expv);
        checkOutput("bit_timing_errors", glitches, 0);
        @(negedge clk);
        checkOutput("tx_stop_done", bus.tx_stop, 1);
        checkOutput("busy_done", bus.busy, 1);
        checkOutput("txd_done", txd, 1);
        @(negedge clk);
        checkOutput("tx_stop_idle", bus.tx_stop, 0);
        checkOutput("busy_idle", bus.busy, 0);
    endtask

    // Line monitor: a low txd while out of reset marks a start bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && txd === 1'b0) monitorFrame();
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input int frames, output int c0);
        @(posedge clk);
        #1;
        bus.tx_data = d;
        bus.tx_en   = 1'b1;
        for (int i = 0; i < frames; i++) sb.push_back(d);
        c0 = cyc;
    endtask

    task automatic releaseRequest();
        @(posedge clk);
        #1;
        bus.tx_en = 1'b0;
    endtask

    task automatic waitStop(input int c0, input int expected_latency, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tx_stop !== 1'b1 && n < 400);
        checkOutput(tag, cyc - c0, expected_latency);
    endtask

    initial begin
        #200_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        int s0;
        int f0;
        bus.tx_en   = 1'b0;
        bus.tx_data = 8'h00;

        $display("[TB] reset check");
        repeat (10) @(posedge clk);
        #1;
        checkOutput("reset_txd", txd, 1);
        checkOutput("reset_tx_stop", bus.tx_stop, 0);
        checkOutput("reset_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_txd", txd, 1);
        checkOutput("idle_busy", bus.busy, 0);

        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5, 1, c0);
        waitStop(c0, STOP_LATENCY, "latency_a5");
        releaseRequest();
        repeat (4) @(posedge clk);

        $display("[TB] data change mid-frame");
        applyStimulus(8'hA5, 1, c0);
        repeat (3 * DIV + 4) @(posedge clk);
        #1;
        bus.tx_data = 8'h00;
        waitStop(c0, STOP_LATENCY, "latency_change");
        releaseRequest();
        repeat (4) @(posedge clk);

        $display("[TB] back-to-back 0x55");
        f0 = fall_q.size();
        applyStimulus(8'h55, 3, c0);
        waitStop(c0, STOP_LATENCY, "latency_b2b_0");
        waitStop(c0, STOP_LATENCY + FRAME_PERIOD, "latency_b2b_1");
        waitStop(c0, STOP_LATENCY + 2 * FRAME_PERIOD, "latency_b2b_2");
        releaseRequest();
        repeat (FRAME_PERIOD + 10) @(posedge clk);
        checkOutput("b2b_frame_count", fall_q.size() - f0, 3);
        if (fall_q.size() - f0 >= 3) begin
            checkOutput("b2b_gap_1", fall_q[f0 + 1] - fall_q[f0], FRAME_PERIOD);
            checkOutput("b2b_gap_2", fall_q[f0 + 2] - fall_q[f0 + 1], FRAME_PERIOD);
        end

        $display("[TB] reset during bit 3");
        applyStimulus(8'h3C, 1, c0);
        repeat (18) @(posedge clk);
        #2;
        s0  = stop_count;
        rst = 1'b0;
        #1;
        checkOutput("abort_txd", txd, 1);
        checkOutput("abort_busy", bus.busy, 0);
        bus.tx_en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        checkOutput("abort_no_tx_stop", stop_count, s0);
        checkOutput("abort_seen", abort_count, 1);
        applyStimulus(8'h0F, 1, c0);
        waitStop(c0, STOP_LATENCY, "latency_0f");
        releaseRequest();
        repeat (4) @(posedge clk);

        $display("[TB] parity patterns 0x07 and 0x03");
        applyStimulus(8'h07, 1, c0);
        waitStop(c0, STOP_LATENCY, "latency_07");
        releaseRequest();
        repeat (4) @(posedge clk);
        applyStimulus(8'h03, 1, c0);
        waitStop(c0, STOP_LATENCY, "latency_03");
        releaseRequest();
        repeat (10) @(posedge clk);

        checkOutput("scoreboard_drained", sb.size(), 0);
        checkOutput("total_tx_stop", stop_count, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
